alu_output_ctrl: RTL and testbench

Output side of the ALU test board: the user-facing counterpart to the switch/button input control.
- Captures the ALU result on a load strobe and mirrors it on the LEDs.
- Drives a 4-digit multiplexed 7-segment display: hex magnitude, with an optional minus sign in signed mode.
- Sits between the ALU result bus and the board's LED, anode and segment pins.

---
 rtl/alu_output_ctrl_pkg.sv | 44 ++++
 rtl/alu_output_ctrl_if.sv | 29 ++
 rtl/alu_output_ctrl_hex_to_7seg.sv | 22 ++
 rtl/alu_output_ctrl.sv | 118 +++++++++++
 tb/tb_alu_output_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_output_ctrl_pkg.sv
// Shared definitions for the ALU board output side: default widths, segment
// patterns, scan states and the hex-to-segment table.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package alu_output_ctrl_pkg;

  localparam int unsigned DEFAULT_N_RESULT = 8;
  localparam int unsigned MAG_W            = 12;
  localparam int unsigned SEG_W            = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_e;

  // Hex digit to active-low segment pattern
  function automatic logic [SEG_W-1:0] hex_seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_output_ctrl_if.sv
// Bus between the ALU result side and the board display pins.
// master: drives result/load/signed, observes led/an/seg/dp.
// slave : the output controller.
interface alu_output_ctrl_if
  import alu_output_ctrl_pkg::*;
#(
  parameter int unsigned N_RESULT = DEFAULT_N_RESULT,
  parameter int unsigned N_DIGITS = 4
);

  logic [N_RESULT-1:0] i_result;
  logic                i_load;
  logic                i_signed;
  logic [N_RESULT-1:0] o_led;
  logic [N_DIGITS-1:0] o_an;
  logic [SEG_W-1:0]    o_seg;
  logic                o_dp;

  modport master (
    output i_result, i_load, i_signed,
    input  o_led, o_an, o_seg, o_dp
  );

  modport slave (
    input  i_result, i_load, i_signed,
    output o_led, o_an, o_seg, o_dp
  );

endinterface

// File: rtl/alu_output_ctrl_hex_to_7seg.sv
// Combinational digit encoder.
// Ports: nibble (hex value), blank (all segments off, highest priority),
// minus (segment g only), seg_c (active-low {g,f,e,d,c,b,a}).
module hex_to_7seg
  import alu_output_ctrl_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  input  logic             minus,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = hex_seg(nibble);
    if (blank) begin
      seg_c = SEG_BLANK;
    end else if (minus) begin
      seg_c = SEG_MINUS;
    end
  end

endmodule

// File: rtl/alu_output_ctrl.sv
// ALU board output controller: captures the ALU result on a load strobe,
// mirrors it on the LEDs and scans a 4-digit multiplexed 7-segment display
// (hex magnitude, leading '-' in signed mode).
// Ports: i_clock, i_reset (sync, active-high); bus (slave) carries
// i_result/i_load/i_signed in and o_led/o_an/o_seg/o_dp out.
module alu_output_ctrl
  import alu_output_ctrl_pkg::*;
#(
  parameter int unsigned N_RESULT    = DEFAULT_N_RESULT,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned N_DIGITS    = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  alu_output_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [N_RESULT-1:0] r_result;
  logic                r_signed;
  logic [CNT_W-1:0]    refresh_cnt;
  scan_state_e         scan_state;
  logic [N_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]    seg_q;

  logic                tick_c;
  logic                neg_c;
  logic [N_RESULT-1:0] mag_n_c;
  logic [MAG_W-1:0]    mag_c;
  logic [3:0]          nibble_c;
  logic                blank_c;
  logic                minus_c;
  logic [SEG_W-1:0]    seg_c;

  // Result capture; reset wins over a simultaneous load
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_result <= '0;
      r_signed <= 1'b0;
    end else if (bus.i_load) begin
      r_result <= bus.i_result;
      r_signed <= bus.i_signed;
    end
  end

  assign tick_c = (refresh_cnt == CNT_MAX);

  // Refresh counter and digit scan FSM (state == digit index)
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      refresh_cnt <= '0;
      scan_state  <= SCAN_D0;
    end else if (tick_c) begin
      refresh_cnt <= '0;
      case (scan_state)
        SCAN_D0: scan_state <= SCAN_D1;
        SCAN_D1: scan_state <= SCAN_D2;
        SCAN_D2: scan_state <= SCAN_D3;
        default: scan_state <= SCAN_D0;
      endcase
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Magnitude in N_RESULT bits; most-negative value stays correct as unsigned
  assign neg_c   = r_signed & r_result[N_RESULT-1];
  assign mag_n_c = neg_c ? N_RESULT'(~r_result + 1'b1) : r_result;
  assign mag_c   = MAG_W'(mag_n_c);

  // Digit select; nibbles entirely above the result width are blanked
  always_comb begin
    nibble_c = '0;
    blank_c  = 1'b0;
    minus_c  = 1'b0;
    case (scan_state)
      SCAN_D0: nibble_c = mag_c[3:0];
      SCAN_D1: begin
        nibble_c = mag_c[7:4];
        blank_c  = (N_RESULT <= 4);
      end
      SCAN_D2: begin
        nibble_c = mag_c[11:8];
        blank_c  = (N_RESULT <= 8);
      end
      default: begin
        blank_c = ~neg_c;
        minus_c = neg_c;
      end
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_c),
    .blank  (blank_c),
    .minus  (minus_c),
    .seg_c  (seg_c)
  );

  // Anode and segment registers update together to avoid ghosting
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(N_DIGITS'(1) << scan_state);
      seg_q <= seg_c;
    end
  end

  assign bus.o_led = r_result;
  assign bus.o_an  = an_q;
  assign bus.o_seg = seg_q;
  assign bus.o_dp  = 1'b1;

endmodule

// File: tb/tb_alu_output_ctrl.sv
module tb_alu_output_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned DIV = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_output_ctrl_if #(.N_RESULT(N), .N_DIGITS(4)) bus ();

  alu_output_ctrl #(.N_RESULT(N), .REFRESH_DIV(DIV), .N_DIGITS(4)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] led;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct packed {
    logic [7:0] v;
    logic       s;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
  } cap_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int unsigned m_cnt = 0;
  int unsigned m_idx = 0;
  logic [7:0]  m_res = 8'h00;
  logic        m_sgn = 1'b0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  cap_t cap_tbl [5] = '{
    '{8'h3C, 1'b0, BLANK, BLANK, 7'b0110000, 7'b1000110},
    '{8'hFB, 1'b1, MINUS, BLANK, 7'b1000000, 7'b0010010},
    '{8'hFB, 1'b0, BLANK, BLANK, 7'b0001110, 7'b0000011},
    '{8'h80, 1'b1, MINUS, BLANK, 7'b0000000, 7'b1000000},
    '{8'h00, 1'b1, BLANK, BLANK, 7'b1000000, 7'b1000000}
  };

  function automatic logic [6:0] ref_seg(input logic [7:0] r, input logic s,
                                         input int unsigned idx);
    logic       neg;
    logic [7:0] mag;
    neg = s & r[7];
    mag = neg ? 8'(-r) : r;
    case (idx)
      0: return hex_tab[mag[3:0]];
      1: return hex_tab[mag[7:4]];
      3: return neg ? MINUS : BLANK;
      default: return BLANK;
    endcase
  endfunction

  // One clock: drive inputs, push the expected post-edge outputs
  task automatic drive(input logic r, input logic ld, input logic [7:0] res,
                       input logic s);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.i_load   = ld;
    bus.i_result = res;
    bus.i_signed = s;
    if (r) begin
      m_res = 8'h00;
      m_sgn = 1'b0;
      m_cnt = 0;
      m_idx = 0;
      e.an  = 4'b1111;
      e.seg = BLANK;
    end else begin
      e.an  = ~(4'b0001 << m_idx);
      e.seg = ref_seg(m_res, m_sgn, m_idx);
      if (ld) begin
        m_res = res;
        m_sgn = s;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.led = m_res;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t       e;
    logic [3:0] want_an;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL reset_sb c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
      end
    end
    checks++;
    if (bus.o_an !== 4'b1111 || bus.o_seg !== 7'b1111111 || bus.o_dp !== 1'b1 ||
        bus.o_led !== 8'h00) begin
      errors++;
      $display("FAIL reset_off: got an=%b seg=%b dp=%b led=%h want an=1111 seg=1111111 dp=1 led=00",
               bus.o_an, bus.o_seg, bus.o_dp, bus.o_led);
    end
    for (int c = 1; c <= 18; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL release_sb c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
      end
      want_an = ~(4'b0001 << (((c - 1) / 4) % 4));
      checks++;
      if (bus.o_an !== want_an || bus.o_dp !== 1'b1) begin
        errors++;
        $display("FAIL release_an c=%0d: got an=%b dp=%b want an=%b dp=1",
                 c, bus.o_an, bus.o_dp, want_an);
      end
    end
  endtask

  task automatic test_capture();
    exp_t       e;
    cap_t       t;
    logic [6:0] want;
    for (int k = 0; k < 5; k++) begin
      t = cap_tbl[k];
      drive(1'b0, 1'b1, t.v, t.s);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== t.v || bus.o_led !== e.led || bus.o_an !== e.an ||
          bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL capture_load k=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 k, bus.o_led, bus.o_an, bus.o_seg, t.v, e.an, e.seg);
      end
      for (int c = 0; c < 17; c++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++;
        if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
          errors++;
          $display("FAIL capture_sb k=%0d c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                   k, c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
        end
        case (bus.o_an)
          4'b1110: want = t.d0;
          4'b1101: want = t.d1;
          4'b1011: want = t.d2;
          4'b0111: want = t.d3;
          default: want = 7'bxxxxxxx;
        endcase
        checks++;
        if (bus.o_seg !== want) begin
          errors++;
          $display("FAIL capture_digit k=%0d c=%0d an=%b: got seg=%b want seg=%b",
                   k, c, bus.o_an, bus.o_seg, want);
        end
      end
    end
  endtask

  task automatic test_reset_load();
    exp_t       e;
    logic [3:0] want_an;
    bit         found;
    drive(1'b0, 1'b1, 8'h55, 1'b0);
    e = sb.pop_front();
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.o_led !== 8'h00 || bus.o_an !== 4'b1111 || bus.o_seg !== BLANK ||
        bus.o_led !== e.led) begin
      errors++;
      $display("FAIL reset_vs_load: got led=%h an=%b seg=%b want led=00 an=1111 seg=1111111",
               bus.o_led, bus.o_an, bus.o_seg);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.o_led !== 8'h00 || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
      errors++;
      $display("FAIL reset_vs_load_after: got led=%h an=%b seg=%b want led=00 an=%b seg=%b",
               bus.o_led, bus.o_an, bus.o_seg, e.an, e.seg);
    end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL midscan_sb c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
      end
      if (bus.o_an === 4'b1011) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midscan_wait: got no an=1011 within 40 cycles want an=1011");
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    e = sb.pop_front();
    checks++;
    if (bus.o_an !== 4'b1111 || bus.o_seg !== BLANK) begin
      errors++;
      $display("FAIL midscan_reset: got an=%b seg=%b want an=1111 seg=1111111",
               bus.o_an, bus.o_seg);
    end
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      want_an = (c <= 4) ? 4'b1110 : 4'b1101;
      checks++;
      if (bus.o_an !== want_an || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL midscan_release c=%0d: got an=%b seg=%b want an=%b seg=%b",
                 c, bus.o_an, bus.o_seg, want_an, e.seg);
      end
    end
  endtask

  task automatic test_mid_load();
    exp_t       e;
    logic [3:0] prev_an;
    bit         found;
    logic [3:0] want_an [4] = '{4'b1101, 4'b1101, 4'b1101, 4'b1011};
    logic [6:0] want_seg [3] = '{7'b1111001, 7'b0010010, 7'b0010010};
    drive(1'b0, 1'b1, 8'h12, 1'b0);
    e = sb.pop_front();
    prev_an = bus.o_an;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL midload_wait_sb c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
      end
      if (bus.o_an === 4'b1101 && prev_an !== 4'b1101) found = 1'b1;
      prev_an = bus.o_an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midload_wait: got no an=1101 entry within 40 cycles want an=1101");
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b0, 1'b1, 8'h5C, 1'b0);
      else        drive(1'b0, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.o_led !== e.led || bus.o_an !== e.an || bus.o_seg !== e.seg) begin
        errors++;
        $display("FAIL midload_sb c=%0d: got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 c, bus.o_led, bus.o_an, bus.o_seg, e.led, e.an, e.seg);
      end
      checks++;
      if (bus.o_an !== want_an[c] || (c < 3 && bus.o_seg !== want_seg[c])) begin
        errors++;
        $display("FAIL midload_digit c=%0d: got an=%b seg=%b want an=%b seg=%b",
                 c, bus.o_an, bus.o_seg, want_an[c], (c < 3) ? want_seg[c] : bus.o_seg);
      end
    end
  endtask

  initial begin
    bus.i_load   = 1'b0;
    bus.i_result = 8'h00;
    bus.i_signed = 1'b0;
    test_reset();
    test_capture();
    test_reset_load();
    test_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
